instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Instruction fetch stage that feeds the decode path (control decoder plus immediate generator). Holds the PC and issues one word request at a time to instruction memory over a valid/ready request channel. Captures the returned word into an IF/ID output register, offered to decode with a valid/ready handshake. Accepts a redirect (branch/jump target) from execute that flushes the output register and any in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request this cycle
imem_addr  out  32  word address of request (= pc)
imem_rsp_valid  in  1  read data valid (one pulse per accepted request, >=1 cycle after acceptance)
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  one-cycle redirect strobe from execute
redirect_pc  in  32  redirect target
id_valid  out  1  IF/ID register holds a valid instruction
id_ready  in  1  decode consumes IF/ID this cycle
id_instr  out  32  fetched instruction
id_pc  out  32  address of id_instr
id_pc_plus4  out  32  id_pc + 4

Behaviour:
- Interface: single clock clk; reset rst is synchronous, active-high.
- Reset: pc=RESET_PC; state=S_REQ; id_valid=0; id_instr=32'h0000_0013 (NOP); id_pc=RESET_PC; id_pc_plus4=RESET_PC+4. Rst beats every other input, including mid-fetch; a response to a pre-reset request arriving after reset is discarded. To do this, reset enters S_DROP if a request was outstanding, otherwise S_REQ.
- imem_addr = pc at all times.
- imem_req_valid = (state==S_REQ) && !id_valid. At most one request is outstanding; no skid buffer is needed.
- States:
  S_REQ: on imem_req_valid && imem_req_ready -> S_WAIT.
  S_WAIT: on imem_rsp_valid -> load id_instr=imem_rsp_data, id_pc=pc, id_pc_plus4=pc+4, id_valid=1; pc<=pc+4; -> S_REQ.
  S_DROP: on imem_rsp_valid -> discard data, no register update; -> S_REQ.
- Latency: response in cycle N gives id_valid=1 in cycle N+1. A new request is issued no earlier than the cycle after id_valid falls.
- Output handshake: id_valid && id_ready in cycle N gives id_valid=0 in N+1, unless a load occurs the same cycle. That cannot happen under the request rule above. Outputs stay stable while id_valid && !id_ready.
- Redirect (redirect_valid=1), in any state, has priority over everything except rst:
  - pc <= {redirect_pc[31:2],2'b00}; low bits are silently cleared.
  - id_valid <= 0, even if id_ready is high the same cycle; the handshake in that cycle counts as consumed.
  - S_REQ, request not accepted this cycle -> stay S_REQ; the next request uses the new pc.
  - S_REQ, request accepted the same cycle -> S_DROP (the accepted address is stale).
  - S_WAIT without imem_rsp_valid -> S_DROP.
  - S_WAIT with imem_rsp_valid the same cycle -> response discarded, -> S_REQ.
  - S_DROP -> stays S_DROP, or goes to S_REQ if imem_rsp_valid the same cycle; pc is updated in either case.
- Arithmetic: pc+4 is a 32-bit modulo add; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- imem_rsp_valid in S_REQ (protocol violation) is ignored.

Decomposition:
- Shared package (riscv_pkg): fetch state encoding (S_REQ=2'd0, S_WAIT=2'd1, S_DROP=2'd2), NOP_INSTR=32'h0000_0013, default RESET_PC, and the ImmSel encodings (I=000, S=001, B=010, U=011, J=100) so the decoder and immediate generator share one definition.
- One natural sub-module: if_id_reg, the IF/ID output register with load/flush/valid-ready. PC and FSM stay in the top module.

Test Plan:
- Reset then free-run: rst 2 cycles, imem ready=1, rsp 1 cycle later returning 32'h00500093, id_ready=1 -> first request addr 0x0; id_instr=0x00500093, id_pc=0x0, id_pc_plus4=0x4; next request addr 0x4.
- Decode stall: id_ready=0 for 5 cycles with id_valid=1 -> id_* stable, imem_req_valid=0 throughout; after id_ready=1, the next request goes to pc+4.
- Redirect during S_WAIT: request to 0x8 accepted, redirect_pc=0x100 before the response -> response for 0x8 dropped, id_valid stays 0, next request addr 0x100, id_pc=0x100.
- Redirect same cycle as accepted request, and separately same cycle as response -> both old words are discarded; fetch resumes at the target. A misaligned target 0x103 fetches 0x100.
- Wrap: RESET_PC=32'hFFFF_FFFC -> id_pc_plus4=0x0, second request addr 0x0.
- Reset mid-fetch: rst asserted in S_WAIT, stale response arrives 2 cycles later -> id_valid=0, stale word never appears, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage and the decode path (decoder and
// immediate generator both read the ImmSel encoding from here).
package riscv_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_sel_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Sequential word address; 32-bit modulo so 0xFFFF_FFFC wraps to 0.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: imem request/response, redirect from execute,
// and the IF/ID handshake toward decode.
interface instr_fetch_unit_if;
  import riscv_pkg::*;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  // Fetch unit side.
  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output id_valid, id_instr, id_pc, id_pc_plus4,
    input  id_ready
  );

  // Environment side: memory, execute and decode.
  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  id_valid, id_instr, id_pc, id_pc_plus4,
    output id_ready
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load from fetch, flush on redirect, cleared
// when decode takes the entry.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc_plus4_in,
  input  logic        ready,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  // Flush wins over load; payload is left untouched unless loaded so it
  // stays stable while decode stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      instr    <= NOP_INSTR;
      pc       <= RESET_PC;
      pc_plus4 <= pc_inc(RESET_PC);
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= instr_in;
      pc       <= pc_in;
      pc_plus4 <= pc_plus4_in;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem request FSM, and the
// IF/ID register. Redirects flush the output and drop any in-flight word.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_fetch_unit_if.master    bus
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt, pc_plus4;
  logic         req_fire, load, flush, outstanding;

  assign pc_plus4           = pc_inc(pc);
  assign bus.imem_addr      = pc;
  // Never fetch while IF/ID is occupied: no skid buffer needed.
  assign bus.imem_req_valid = (state == S_REQ) && !bus.id_valid;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // A request is still owed a response after this cycle; reset must then
  // park in S_DROP so the stale word is swallowed.
  assign outstanding = (state == S_REQ  && req_fire) ||
                       (state == S_WAIT && !bus.imem_rsp_valid) ||
                       (state == S_DROP && !bus.imem_rsp_valid);

  // Next-state, PC update and IF/ID load/flush; redirect beats the normal flow.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    load      = 1'b0;
    flush     = 1'b0;
    if (bus.redirect_valid) begin
      flush  = 1'b1;
      pc_nxt = bus.redirect_pc & ~32'h3;
      unique case (state)
        S_REQ:   state_nxt = req_fire ? S_DROP : S_REQ;
        S_WAIT,
        S_DROP:  state_nxt = bus.imem_rsp_valid ? S_REQ : S_DROP;
        default: state_nxt = S_REQ;
      endcase
    end else begin
      unique case (state)
        S_REQ:   if (req_fire) state_nxt = S_WAIT;
        S_WAIT:  if (bus.imem_rsp_valid) begin
                   load      = 1'b1;
                   pc_nxt    = pc_plus4;
                   state_nxt = S_REQ;
                 end
        S_DROP:  if (bus.imem_rsp_valid) state_nxt = S_REQ;
        default: state_nxt = S_REQ;
      endcase
    end
  end

  // PC and FSM state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      state <= outstanding ? S_DROP : S_REQ;
    end else begin
      pc    <= pc_nxt;
      state <= state_nxt;
    end
  end

  if_id_reg #(.RESET_PC(RESET_PC)) u_if_id (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .flush       (flush),
    .instr_in    (bus.imem_rsp_data),
    .pc_in       (pc),
    .pc_plus4_in (pc_plus4),
    .ready       (bus.id_ready),
    .valid       (bus.id_valid),
    .instr       (bus.id_instr),
    .pc          (bus.id_pc),
    .pc_plus4    (bus.id_pc_plus4)
  );

endmodule
